secuenciador_ventana: RTL and testbench

Upstream feeder for the 5-byte window divider. Accepts 64-bit image words (8 pixels) over a valid/ready handshake and holds each word on `datos`. For every word it steps `seleccion` through 0,1,2,3 so the divider presents each of its four circular 5-byte window positions. It also tracks word position within an image row and flags the last window of each row.

---
 rtl/secuenciador_ventana.sv | 128 ++++++++++++
 tb/tb_secuenciador_ventana.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_ventana.sv
// rtl/secuenciador_ventana.sv - feeds 64-bit words to the 5-byte window divider, stepping seleccion 0..3 per word.
// Optional one-word prefetch register enabled by SECUENCIADOR_PREFETCH_EN.
module secuenciador_ventana #(
    parameter int PALABRAS_FILA = 4,
    parameter int ANCHO_CONT    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] entrada_datos,
    input  logic        entrada_valida,
    output logic        entrada_listo,
    output logic [63:0] datos,
    output logic [1:0]  seleccion,
    output logic        salida_valida,
    input  logic        salida_listo,
    output logic        fin_fila,
    input  logic        vaciar
);

    typedef enum logic {VACIO, ACTIVO} estado_t;

    localparam logic [ANCHO_CONT-1:0] CONT_MAX = ANCHO_CONT'(PALABRAS_FILA - 1);

    estado_t               estado, estado_sig;
    logic [63:0]           datos_q, datos_sig;
    logic [1:0]            sel_q, sel_sig;
    logic [ANCHO_CONT-1:0] cont_q, cont_sig;
    logic                  transf_ent, transf_sal, retiro;

`ifdef SECUENCIADOR_PREFETCH_EN
    logic [63:0]           siguiente_q, siguiente_sig;
    logic                  lleno_q, lleno_sig;

    assign entrada_listo = !lleno_q && !vaciar;
`else
    assign entrada_listo = (estado == VACIO) && !vaciar;
`endif

    assign salida_valida = (estado == ACTIVO);
    assign datos         = datos_q;
    assign seleccion     = sel_q;
    assign fin_fila      = salida_valida && (sel_q == 2'd3) && (cont_q == CONT_MAX);

    assign transf_ent = entrada_valida && entrada_listo;
    assign transf_sal = salida_valida && salida_listo;
    assign retiro     = transf_sal && (sel_q == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado  <= VACIO;
            datos_q <= '0;
            sel_q   <= '0;
            cont_q  <= '0;
`ifdef SECUENCIADOR_PREFETCH_EN
            siguiente_q <= '0;
            lleno_q     <= 1'b0;
`endif
        end else begin
            estado  <= estado_sig;
            datos_q <= datos_sig;
            sel_q   <= sel_sig;
            cont_q  <= cont_sig;
`ifdef SECUENCIADOR_PREFETCH_EN
            siguiente_q <= siguiente_sig;
            lleno_q     <= lleno_sig;
`endif
        end
    end

    always_comb begin
        estado_sig = estado;
        datos_sig  = datos_q;
        sel_sig    = sel_q;
        cont_sig   = cont_q;
`ifdef SECUENCIADOR_PREFETCH_EN
        siguiente_sig = siguiente_q;
        lleno_sig     = lleno_q;
`endif
        // Flush wins over everything; datos is deliberately left untouched.
        if (vaciar) begin
            estado_sig = VACIO;
            sel_sig    = '0;
            cont_sig   = '0;
`ifdef SECUENCIADOR_PREFETCH_EN
            lleno_sig  = 1'b0;
`endif
        end else begin
            case (estado)
                VACIO: begin
                    if (transf_ent) begin
                        datos_sig  = entrada_datos;
                        sel_sig    = '0;
                        estado_sig = ACTIVO;
                    end
                end
                ACTIVO: begin
`ifdef SECUENCIADOR_PREFETCH_EN
                    // A word arriving on the retirement cycle bypasses siguiente.
                    if (transf_ent && !retiro) begin
                        siguiente_sig = entrada_datos;
                        lleno_sig     = 1'b1;
                    end
`endif
                    if (transf_sal && !retiro) begin
                        sel_sig = sel_q + 2'd1;
                    end else if (retiro) begin
                        sel_sig  = '0;
                        cont_sig = (cont_q == CONT_MAX) ? '0 : cont_q + ANCHO_CONT'(1);
`ifdef SECUENCIADOR_PREFETCH_EN
                        if (lleno_q) begin
                            datos_sig = siguiente_q;
                            lleno_sig = 1'b0;
                        end else if (transf_ent) begin
                            datos_sig = entrada_datos;
                        end else begin
                            estado_sig = VACIO;
                        end
`else
                        estado_sig = VACIO;
`endif
                    end
                end
                default: estado_sig = VACIO;
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_ventana.sv
// tb/tb_secuenciador_ventana.sv - directed bench for secuenciador_ventana (PALABRAS_FILA=2); honours SECUENCIADOR_PREFETCH_EN.
module tb_secuenciador_ventana;

    logic        clk;
    logic        reset_n;
    logic [63:0] entrada_datos;
    logic        entrada_valida;
    logic        entrada_listo;
    logic [63:0] datos;
    logic [1:0]  seleccion;
    logic        salida_valida;
    logic        salida_listo;
    logic        fin_fila;
    logic        vaciar;

    int checks   = 0;
    int failures = 0;

    secuenciador_ventana #(.PALABRAS_FILA(2), .ANCHO_CONT(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .entrada_datos  (entrada_datos),
        .entrada_valida (entrada_valida),
        .entrada_listo  (entrada_listo),
        .datos          (datos),
        .seleccion      (seleccion),
        .salida_valida  (salida_valida),
        .salida_listo   (salida_listo),
        .fin_fila       (fin_fila),
        .vaciar         (vaciar)
    );

    always #5 clk = ~clk;

`ifdef SECUENCIADOR_PREFETCH_EN
    localparam int SPAN_ESP   = 8 * 4 + 1;
    localparam bit LISTO_ACT  = 1'b1;
`else
    localparam int SPAN_ESP   = 8 * 5;
    localparam bit LISTO_ACT  = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic flanco();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] pal(input int k);
        return {32'hCAFE0000 + 32'(k), 32'h00001000 * 32'(k + 1)};
    endfunction

    task automatic enviar_palabra(input string tag, input logic [63:0] w, input logic fin_esp);
        entrada_datos  = w;
        entrada_valida = 1'b1;
        salida_listo   = 1'b1;
        #1;
        check_val({tag, "_listo"}, 64'(entrada_listo), 64'd1);
        flanco();
        entrada_valida = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_val({tag, "_valida"}, 64'(salida_valida), 64'd1);
            check_val({tag, "_sel"}, 64'(seleccion), 64'(i));
            check_val({tag, "_datos"}, datos, w);
            check_val({tag, "_fin"}, 64'(fin_fila), 64'(fin_esp && i == 3));
            flanco();
        end
        check_val({tag, "_vacio"}, 64'(salida_valida), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n_in, c0, cl;
        clk = 1'b0;
        reset_n = 1'b1;
        entrada_datos = '0;
        entrada_valida = 1'b0;
        salida_listo = 1'b0;
        vaciar = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_datos", datos, 64'd0);
        check_val("rst_sel", 64'(seleccion), 64'd0);
        check_val("rst_valida", 64'(salida_valida), 64'd0);
        check_val("rst_fin", 64'(fin_fila), 64'd0);
        check_val("rst_listo", 64'(entrada_listo), 64'd1);
        flanco();
        flanco();
        reset_n = 1'b1;
        #1;

        // single word, four windows (row word 0)
        enviar_palabra("w1", 64'h0102030405060708, 1'b0);

        // stall at seleccion=1; this is row word 1 so its last window ends the row
        entrada_datos = 64'h1122334455667788;
        entrada_valida = 1'b1;
        salida_listo = 1'b1;
        #1;
        flanco();
        entrada_valida = 1'b0;
        #1;
        check_val("st_sel0", 64'(seleccion), 64'd0);
        check_val("st_listo_act", 64'(entrada_listo), 64'(LISTO_ACT));
        flanco();
        salida_listo = 1'b0;
        #1;
        repeat (3) begin
            check_val("st_sel_hold", 64'(seleccion), 64'd1);
            check_val("st_datos_hold", datos, 64'h1122334455667788);
            check_val("st_valida_hold", 64'(salida_valida), 64'd1);
            flanco();
        end
        salida_listo = 1'b1;
        #1;
        check_val("st_sel_still", 64'(seleccion), 64'd1);
        flanco();
        check_val("st_sel2", 64'(seleccion), 64'd2);
        flanco();
        check_val("st_sel3", 64'(seleccion), 64'd3);
        check_val("st_fin", 64'(fin_fila), 64'd1);
        flanco();
        check_val("st_vacio", 64'(salida_valida), 64'd0);

        // continuous stream of 8 words
        n_in = 0; w = 0; c0 = -1; cl = 0;
        entrada_datos = pal(0);
        entrada_valida = 1'b1;
        salida_listo = 1'b1;
        for (int ciclo = 0; ciclo < 200 && w < 32; ciclo++) begin
            #1;
            if (entrada_valida && entrada_listo) begin
                if (n_in == 0) c0 = ciclo;
                n_in++;
            end
            if (salida_valida && salida_listo) begin
                check_val("str_datos", datos, pal(w / 4));
                check_val("str_sel", 64'(seleccion), 64'(w % 4));
                check_val("str_fin", 64'(fin_fila), 64'(w % 8 == 7));
                cl = ciclo;
                w++;
            end
            flanco();
            entrada_valida = (n_in < 8);
            entrada_datos = pal(n_in);
        end
        #1;
        check_val("str_ventanas", 64'(w), 64'd32);
        check_val("str_palabras", 64'(n_in), 64'd8);
        check_val("str_ciclos", 64'(cl - c0 + 1), 64'(SPAN_ESP));
        check_val("str_vacio", 64'(salida_valida), 64'd0);

        // flush at seleccion=2 with a pending (prefetched) word, row counter at 1
        enviar_palabra("x", 64'hAAAA0000AAAA0000, 1'b0);
        entrada_datos = 64'hC0C0C0C0C0C0C0C0;
        entrada_valida = 1'b1;
        #1;
        flanco();
        entrada_datos = 64'hD0D0D0D0D0D0D0D0;
        #1;
        flanco();
        entrada_valida = 1'b0;
        #1;
        check_val("vac_sel1", 64'(seleccion), 64'd1);
        flanco();
        vaciar = 1'b1;
        entrada_datos = 64'hE0E0E0E0E0E0E0E0;
        entrada_valida = 1'b1;
        #1;
        check_val("vac_listo", 64'(entrada_listo), 64'd0);
        check_val("vac_sel2", 64'(seleccion), 64'd2);
        flanco();
        vaciar = 1'b0;
        entrada_valida = 1'b0;
        #1;
        check_val("vac_valida", 64'(salida_valida), 64'd0);
        check_val("vac_sel", 64'(seleccion), 64'd0);
        check_val("vac_datos", datos, 64'hC0C0C0C0C0C0C0C0);
        check_val("vac_listo_post", 64'(entrada_listo), 64'd1);
        enviar_palabra("f", 64'hF0F0F0F0F0F0F0F0, 1'b0);
        enviar_palabra("g", 64'h0F0F0F0F0F0F0F0F, 1'b1);

        // asynchronous reset mid-word, row counter at 1
        enviar_palabra("y", 64'h5555555555555555, 1'b0);
        entrada_datos = 64'h1234567812345678;
        entrada_valida = 1'b1;
        #1;
        flanco();
        entrada_valida = 1'b0;
        #1;
        flanco();
        #1;
        check_val("ar_sel_pre", 64'(seleccion), 64'd1);
        reset_n = 1'b0;
        #1;
        check_val("ar_datos", datos, 64'd0);
        check_val("ar_sel", 64'(seleccion), 64'd0);
        check_val("ar_valida", 64'(salida_valida), 64'd0);
        check_val("ar_fin", 64'(fin_fila), 64'd0);
        check_val("ar_listo", 64'(entrada_listo), 64'd1);
        flanco();
        flanco();
        reset_n = 1'b1;
        #1;
        enviar_palabra("j", 64'h9999888877776666, 1'b0);
        enviar_palabra("k", 64'h6666777788889999, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
